// File: rtl/ssd_capture_pkg.sv
// Shared definitions for the seven-segment capture block, the display
// scanner and their benches: segment bit order, blank pattern and FSM states.
package ssd_capture_pkg;

    localparam int unsigned DIGIT_W    = 7;
    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned PAT_W      = NUM_DIGITS + DIGIT_W;

    // Active-low segments: all ones means every segment is dark.
    localparam logic [DIGIT_W-1:0]    SEG_OFF = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_NONE = 4'hF;

    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned SEG_B_BIT = 5;
    localparam int unsigned SEG_C_BIT = 4;
    localparam int unsigned SEG_D_BIT = 3;
    localparam int unsigned SEG_E_BIT = 2;
    localparam int unsigned SEG_F_BIT = 1;
    localparam int unsigned SEG_G_BIT = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } ssd_state_e;

    // Number of anode lines driven low.
    function automatic logic [2:0] count_low(input logic [NUM_DIGITS-1:0] an);
        count_low = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) count_low = count_low + 3'd1;
        end
    endfunction

    // Position of the (highest) low anode line; meaningful only when exactly one is low.
    function automatic logic [1:0] low_index(input logic [NUM_DIGITS-1:0] an);
        low_index = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) low_index = 2'(i);
        end
    endfunction

endpackage

// File: rtl/ssd_capture_if.sv
// Display bus seen by the capture block: raw segment/anode lines in,
// rebuilt digits and status flags out.
interface ssd_capture_if;
    import ssd_capture_pkg::*;

    logic a, b, c, d, e, f, g;
    logic an0, an1, an2, an3;

    logic [DIGIT_W-1:0] digit0;
    logic [DIGIT_W-1:0] digit1;
    logic [DIGIT_W-1:0] digit2;
    logic [DIGIT_W-1:0] digit3;
    logic               frame_done;
    logic               changed;
    logic               stale;
    logic               anode_err;

    // Side that drives the display lines and reads back the capture results.
    modport master (
        output a, b, c, d, e, f, g,
        output an0, an1, an2, an3,
        input  digit0, digit1, digit2, digit3,
        input  frame_done, changed, stale, anode_err
    );

    // Capture block side.
    modport slave (
        input  a, b, c, d, e, f, g,
        input  an0, an1, an2, an3,
        output digit0, digit1, digit2, digit3,
        output frame_done, changed, stale, anode_err
    );
endinterface

// File: rtl/ssd_capture_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
module ssd_capture_sync2 #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; second stage gives it a cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ssd_capture.sv
// Seven-segment bus reader: rebuilds the four static digits from the
// multiplexed segment/anode lines and reports frame, change and stale status.
//
// state  | meaning
// IDLE   | no anode low, or an illegal multi-anode pattern
// SETTLE | exactly one anode low, waiting for the pattern to hold
// HELD   | current dwell captured, waiting for the next pattern change
import ssd_capture_pkg::*;

module ssd_capture #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    ssd_capture_if.slave bus
);

    localparam int unsigned STALE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_CYCLES);
    localparam logic [PAT_W-1:0]   PAT_IDLE  = {AN_NONE, SEG_OFF};

    logic [DIGIT_W-1:0]    raw_seg;
    logic [PAT_W-1:0]      raw_bus;
    logic [PAT_W-1:0]      sync_bus;
    logic [PAT_W-1:0]      pat_q;
    logic [7:0]            settle_cnt_q;
    logic [7:0]            settle_cnt_d;
    logic                  pat_change;
    logic                  settle_done;
    logic                  capture;
    logic [NUM_DIGITS-1:0] sync_an;
    logic [NUM_DIGITS-1:0] pat_an;
    logic [DIGIT_W-1:0]    pat_seg;
    logic [1:0]            pat_idx;

    ssd_state_e                          state_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digit_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  snap_q;
    logic                                snap_valid_q;
    logic [NUM_DIGITS-1:0]               seen_q;
    logic [NUM_DIGITS-1:0]               seen_d;
    logic                                frame_done_q;
    logic                                changed_q;
    logic                                anode_err_q;
    logic [STALE_W-1:0]                  stale_cnt_q;

    // Gather the segment lines into digit bit order.
    always_comb begin
        raw_seg            = SEG_OFF;
        raw_seg[SEG_A_BIT] = bus.a;
        raw_seg[SEG_B_BIT] = bus.b;
        raw_seg[SEG_C_BIT] = bus.c;
        raw_seg[SEG_D_BIT] = bus.d;
        raw_seg[SEG_E_BIT] = bus.e;
        raw_seg[SEG_F_BIT] = bus.f;
        raw_seg[SEG_G_BIT] = bus.g;
    end

    assign raw_bus = {bus.an3, bus.an2, bus.an1, bus.an0, raw_seg};

    // Idle bus level is all-high, so the synchronizer resets to that to avoid
    // a spurious pattern change right after reset.
    ssd_capture_sync2 #(
        .WIDTH     (PAT_W),
        .RESET_VAL (PAT_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (raw_bus),
        .q_o   (sync_bus)
    );

    assign sync_an    = sync_bus[PAT_W-1 -: NUM_DIGITS];
    assign pat_an     = pat_q[PAT_W-1 -: NUM_DIGITS];
    assign pat_seg    = pat_q[DIGIT_W-1:0];
    assign pat_idx    = low_index(pat_an);
    assign pat_change = (sync_bus != pat_q);

    // The counter reaching SETTLE_CYCLES on this edge is the capture point, so
    // a dwell is captured exactly once however long it lasts.
    assign settle_done = !pat_change && (settle_cnt_q == SETTLE_LAST);
    assign capture     = (state_q == SETTLE) && settle_done;

    // Settle counter: restart on any pattern change, otherwise saturate.
    always_comb begin
        settle_cnt_d = settle_cnt_q;
        if (pat_change) begin
            settle_cnt_d = 8'd0;
        end else if (settle_cnt_q != SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q + 8'd1;
        end
    end

    // Pattern register and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q        <= PAT_IDLE;
            settle_cnt_q <= 8'd0;
        end else begin
            pat_q        <= sync_bus;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    // Seen mask: a completed frame clears it in the same edge the pulse is raised.
    always_comb begin
        seen_d = (seen_q == 4'hF) ? 4'h0 : seen_q;
        if (capture) seen_d[pat_idx] = 1'b1;
    end

    // Capture FSM with digit, frame and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            digit_q      <= {NUM_DIGITS{SEG_OFF}};
            snap_q       <= {NUM_DIGITS{SEG_OFF}};
            snap_valid_q <= 1'b0;
            seen_q       <= 4'h0;
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            anode_err_q  <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            changed_q    <= 1'b0;
            seen_q       <= seen_d;

            if (pat_change) begin
                state_q <= (count_low(sync_an) == 3'd1) ? SETTLE : IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (settle_done && (count_low(pat_an) >= 3'd2)) begin
                            anode_err_q <= 1'b1;
                        end
                    end
                    SETTLE: begin
                        if (capture) begin
                            digit_q[pat_idx] <= pat_seg;
                            state_q          <= HELD;
                        end
                    end
                    HELD: begin
                        state_q <= HELD;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end

            // The first frame after reset has nothing valid to compare against.
            if (seen_q == 4'hF) begin
                frame_done_q <= 1'b1;
                changed_q    <= !snap_valid_q || (digit_q != snap_q);
                snap_q       <= digit_q;
                snap_valid_q <= 1'b1;
            end
        end
    end

    // Stale timer: cleared by every capture, saturates at the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt_q <= '0;
        end else if (capture) begin
            stale_cnt_q <= '0;
        end else if (stale_cnt_q != STALE_MAX) begin
            stale_cnt_q <= stale_cnt_q + STALE_W'(1);
        end
    end

    assign bus.digit0     = digit_q[0];
    assign bus.digit1     = digit_q[1];
    assign bus.digit2     = digit_q[2];
    assign bus.digit3     = digit_q[3];
    assign bus.frame_done = frame_done_q;
    assign bus.changed    = changed_q;
    assign bus.stale      = (stale_cnt_q == STALE_MAX);
    assign bus.anode_err  = anode_err_q;

endmodule

// File: tb/tb_ssd_capture.sv
// Bench for ssd_capture: dwell-level reference model feeding an expected-frame
// queue, with a monitor that checks every frame_done pulse against it.
module tb_ssd_capture;
    import ssd_capture_pkg::*;

    localparam int S = 4;
    localparam int T = 64;

    typedef struct packed {
        logic [27:0] digits;
        logic        chg;
    } frame_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ssd_capture_if bus_if();

    ssd_capture #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_frames_exp = 0;
    int n_frames_got = 0;

    frame_t            exp_q[$];
    logic [3:0][6:0]   m_dig;
    logic [3:0][6:0]   m_snap;
    logic [3:0]        m_seen;
    bit                m_first;
    logic [3:0]        prev_an;
    logic [6:0]        prev_seg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_dig   = {4{SEG_OFF}};
        m_snap  = {4{SEG_OFF}};
        m_seen  = 4'h0;
        m_first = 1'b1;
    endtask

    // One captured dwell: record the digit, and close the frame once all four are in.
    task automatic model_capture(input int idx, input logic [6:0] seg);
        frame_t fr;
        m_dig[idx]  = seg;
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            fr.digits = m_dig;
            fr.chg    = m_first || (m_dig != m_snap);
            exp_q.push_back(fr);
            n_frames_exp++;
            m_snap  = m_dig;
            m_first = 1'b0;
            m_seen  = 4'h0;
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        {bus_if.an3, bus_if.an2, bus_if.an1, bus_if.an0} = an;
        {bus_if.a, bus_if.b, bus_if.c, bus_if.d, bus_if.e, bus_if.f, bus_if.g} = seg;
        prev_an  = an;
        prev_seg = seg;
    endtask

    // Hold a pattern for d clock edges. A legal pattern held S+2 or more is captured.
    task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int d);
        drive(an, seg);
        if ($countones(~an) == 1 && d >= S + 2) begin
            for (int i = 0; i < 4; i++) begin
                if (!an[i]) model_capture(i, seg);
            end
        end
        repeat (d) @(negedge clk);
    endtask

    task automatic idle(input int d);
        dwell(AN_NONE, SEG_OFF, d);
    endtask

    task automatic scan(input logic [27:0] vals, input int d);
        for (int i = 0; i < 4; i++) begin
            dwell(~(4'(1) << i), vals[i*7 +: 7], d);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digit0"}, bus_if.digit0, SEG_OFF);
        check({tag, "_digit1"}, bus_if.digit1, SEG_OFF);
        check({tag, "_digit2"}, bus_if.digit2, SEG_OFF);
        check({tag, "_digit3"}, bus_if.digit3, SEG_OFF);
        check({tag, "_frame_done"}, bus_if.frame_done, 0);
        check({tag, "_changed"}, bus_if.changed, 0);
        check({tag, "_stale"}, bus_if.stale, 0);
        check({tag, "_anode_err"}, bus_if.anode_err, 0);
    endtask

    task automatic check_digits(input string tag);
        check({tag, "_digit0"}, bus_if.digit0, m_dig[0]);
        check({tag, "_digit1"}, bus_if.digit1, m_dig[1]);
        check({tag, "_digit2"}, bus_if.digit2, m_dig[2]);
        check({tag, "_digit3"}, bus_if.digit3, m_dig[3]);
    endtask

    // Monitor: every frame_done pulse must match the oldest expected frame.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_if.frame_done === 1'b1) begin
                n_frames_got++;
                check("frame_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    frame_t fr;
                    fr = exp_q.pop_front();
                    check("frame_digits",
                          {bus_if.digit3, bus_if.digit2, bus_if.digit1, bus_if.digit0},
                          fr.digits);
                    check("frame_changed", bus_if.changed, fr.chg);
                end
            end else begin
                check("changed_without_frame", bus_if.changed, 0);
            end
        end
    end

    localparam logic [27:0] VALS1 = {7'h30, 7'h24, 7'h79, 7'h40};
    localparam logic [27:0] VALS2 = {7'h30, 7'h19, 7'h79, 7'h40};

    initial begin
        logic [3:0] r_an;
        logic [6:0] r_seg;
        int         r_len;

        model_reset();
        rst_n = 1'b1;
        drive(AN_NONE, SEG_OFF);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Quiet bus: stale rises exactly on the T-th edge after release.
        repeat (T - 1) @(negedge clk);
        check("stale_before_timeout", bus_if.stale, 0);
        @(negedge clk);
        check("stale_at_timeout", bus_if.stale, 1);
        check("quiet_digit0", bus_if.digit0, SEG_OFF);

        // First scan: all digits captured, first frame reports a change.
        scan(VALS1, 8);
        idle(4);
        check("stale_cleared", bus_if.stale, 0);
        check_digits("scan1");

        // Identical scan then one digit changed.
        scan(VALS1, 8);
        scan(VALS2, 8);
        idle(4);
        check_digits("scan3");

        // Too-short dwell on an1 must not capture nor mark the digit seen.
        dwell(4'b1101, 7'h00, 3);
        idle(4);
        check("short_dwell_digit1", bus_if.digit1, 7'h79);
        dwell(4'b1110, 7'h40, 8);
        dwell(4'b1011, 7'h24, 8);
        dwell(4'b0111, 7'h30, 8);
        idle(6);
        check("no_frame_without_digit1", 32'(exp_q.size()), 0);
        dwell(4'b1101, 7'h79, 8);
        idle(4);

        // Two anodes low: sticky error, nothing written, scanning still works.
        dwell(4'b1010, 7'h11, 6);
        idle(4);
        check("anode_err_set", bus_if.anode_err, 1);
        check_digits("illegal");
        scan(VALS2, 8);
        idle(4);
        check("anode_err_sticky", bus_if.anode_err, 1);

        // Random dwells: mix of idle, short and long legal patterns.
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                r_an = AN_NONE;
            end else begin
                r_an = ~(4'(1) << $urandom_range(0, 3));
            end
            r_seg = 7'($urandom);
            if (r_an == prev_an && r_seg == prev_seg) r_seg = r_seg ^ 7'h01;
            if ($urandom_range(0, 1) == 0) r_len = $urandom_range(1, S - 1);
            else                           r_len = $urandom_range(S + 2, S + 6);
            dwell(r_an, r_seg, r_len);
        end
        idle(8);
        check_digits("random");

        // Reset part-way through a frame.
        scan(VALS1, 8);
        dwell(4'b1110, 7'h12, 8);
        dwell(4'b1101, 7'h34, 8);
        check("queue_empty_before_reset", 32'(exp_q.size()), 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        idle(4);
        scan(VALS1, 8);
        idle(8);
        check_digits("after_reset");

        check("queue_drained", 32'(exp_q.size()), 0);
        check("frame_count", n_frames_got, n_frames_exp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
